// File: rtl/l2_mem_adaptor.sv
// l2_mem_adaptor: bridges 256-bit cache line requests to four 64-bit memory
// beats. Reads assemble beats into line_o; writes stream a latched line out
// low beat first. A one-cycle resp_o pulse marks completion.
// Optional feature macro: L2_ADAPTOR_PERF_EN adds completed-line counters
// rd_count_o / wr_count_o.
module l2_mem_adaptor (
  input  logic         clk,
  input  logic         rst,
  // cache side
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  // memory side
  output logic [63:0]  burst_o,
  input  logic [63:0]  burst_i,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
`ifdef L2_ADAPTOR_PERF_EN
  ,
  output logic [31:0]  rd_count_o,
  output logic [31:0]  wr_count_o
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] address_reg;
  logic [63:0] rd_beat_reg [4];
  logic [63:0] wr_beat_reg [4];

  logic        accept_rd;
  logic        accept_wr;
  logic        rd_store;

  // Next-state, beat counter and output decode; outputs come only from registers.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept_rd  = 1'b0;
    accept_wr  = 1'b0;
    rd_store   = 1'b0;
    read_o     = 1'b0;
    write_o    = 1'b0;
    resp_o     = 1'b0;
    burst_o    = 64'd0;
    case (state_reg)
      IDLE: begin
        // read has priority when both requests arrive together
        if (read_i) begin
          accept_rd  = 1'b1;
          cnt_next   = 2'd0;
          state_next = RD_BURST;
        end else if (write_i) begin
          accept_wr  = 1'b1;
          cnt_next   = 2'd0;
          state_next = WR_BURST;
        end
      end
      RD_BURST: begin
        read_o = 1'b1;
        if (resp_i) begin
          rd_store = 1'b1;
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = DONE;
        end
      end
      WR_BURST: begin
        write_o = 1'b1;
        burst_o = wr_beat_reg[cnt_reg];
        if (resp_i) begin
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = DONE;
        end
      end
      DONE: begin
        resp_o     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Line-aligned burst address, held until the next accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      address_reg <= 32'd0;
    end else if (accept_rd || accept_wr) begin
      address_reg <= address_i & ~32'h0000_001F;
    end
  end

  assign address_o = address_reg;

  // One storage slice per 64-bit beat for both the read line and write line.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_beat
      // Read beat gi captured when the counter points at it.
      always_ff @(posedge clk) begin
        if (!rst) begin
          rd_beat_reg[gi] <= 64'd0;
        end else if (rd_store && (cnt_reg == 2'(gi))) begin
          rd_beat_reg[gi] <= burst_i;
        end
      end

      // Write line slice gi latched when a write is accepted.
      always_ff @(posedge clk) begin
        if (!rst) begin
          wr_beat_reg[gi] <= 64'd0;
        end else if (accept_wr) begin
          wr_beat_reg[gi] <= line_i[64*gi +: 64];
        end
      end

      assign line_o[64*gi +: 64] = rd_beat_reg[gi];
    end
  endgenerate

`ifdef L2_ADAPTOR_PERF_EN
  logic        op_rd_reg;
  logic [31:0] rd_count_reg;
  logic [31:0] wr_count_reg;

  // Remember which kind of transfer is in flight for the DONE-cycle count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_rd_reg <= 1'b0;
    end else if (accept_rd) begin
      op_rd_reg <= 1'b1;
    end else if (accept_wr) begin
      op_rd_reg <= 1'b0;
    end
  end

  // Completed-line counters, wrapping naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_count_reg <= 32'd0;
      wr_count_reg <= 32'd0;
    end else if (state_reg == DONE) begin
      if (op_rd_reg) rd_count_reg <= rd_count_reg + 32'd1;
      else           wr_count_reg <= wr_count_reg + 32'd1;
    end
  end

  assign rd_count_o = rd_count_reg;
  assign wr_count_o = wr_count_reg;
`endif

endmodule

// File: tb/tb_l2_mem_adaptor.sv
// Testbench for l2_mem_adaptor: directed stimulus pushes expected completions
// and write beats into queues; a negedge monitor pops and compares whenever
// the DUT presents resp_o or write_o.
module tb_l2_mem_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_o;
  logic [63:0]  burst_i;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;
`ifdef L2_ADAPTOR_PERF_EN
  logic [31:0]  rd_count;
  logic [31:0]  wr_count;
`endif

  l2_mem_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_o   (burst_o),
    .burst_i   (burst_i),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
`ifdef L2_ADAPTOR_PERF_EN
    ,
    .rd_count_o(rd_count),
    .wr_count_o(wr_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] line;
    logic [31:0]  addr;
    int unsigned  cyc;
  } resp_t;

  resp_t        resp_q [$];
  logic [63:0]  beat_q [$];
  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;
  logic [255:0] last_line = '0;
  logic [31:0]  last_addr = '0;
  int           exp_rd = 0;
  int           exp_wr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a completion or write beat.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (resp_o) begin
        if (resp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_resp: got resp_o=1 at cycle %0d expected none", cyc);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          check("resp_line_o", line_o, e.line);
          check("resp_address_o", {224'd0, address_o}, {224'd0, e.addr});
          check("resp_cycle", 256'(cyc), 256'(e.cyc));
          $display("[TB] completion cycle %0d addr %0h line %0h", cyc, address_o, line_o);
        end
      end
      if (write_o) begin
        if (beat_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_write_beat: got burst_o=%0h expected no write", burst_o);
        end else begin
          logic [63:0] b;
          b = beat_q.pop_front();
          check("write_burst_o", {192'd0, burst_o}, {192'd0, b});
          $display("[TB] write beat cycle %0d burst_o %0h resp_i %0b", cyc, burst_o, resp_i);
        end
      end else begin
        check("burst_o_idle_zero", {192'd0, burst_o}, 256'd0);
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [63:0] b0, input logic [63:0] b1,
                         input logic [63:0] b2, input logic [63:0] b3,
                         input bit also_write);
    resp_t e;
    logic [63:0] b [4];
    b = '{b0, b1, b2, b3};
    read_i = 1'b1; write_i = also_write; address_i = addr;
    line_i = {4{64'hFEED_FACE_0BAD_F00D}};
    e.line = {b3, b2, b1, b0}; e.addr = exp_addr; e.cyc = cyc + 5;
    resp_q.push_back(e);
    last_line = e.line; last_addr = exp_addr;
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
    if (also_write) begin
      check("both_read_o", {255'd0, read_o}, 256'd1);
      check("both_write_o", {255'd0, write_o}, 256'd0);
    end
    for (int i = 0; i < 4; i++) begin
      burst_i = b[i]; resp_i = 1'b1;
      @(posedge clk); #1;
    end
    resp_i = 1'b0; burst_i = 64'd0;
    @(posedge clk); #1;
    exp_rd++;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] exp_addr,
                          input logic [63:0] b0, input logic [63:0] b1,
                          input logic [63:0] b2, input logic [63:0] b3,
                          input logic [7:0] pat, input int len);
    resp_t e;
    int k;
    logic [63:0] b [4];
    b = '{b0, b1, b2, b3};
    write_i = 1'b1; address_i = addr; line_i = {b3, b2, b1, b0};
    e.line = last_line; e.addr = exp_addr; e.cyc = cyc + 1 + len;
    resp_q.push_back(e);
    last_addr = exp_addr;
    @(posedge clk); #1;
    write_i = 1'b0; line_i = '0;
    k = 0;
    for (int i = 0; i < len; i++) begin
      resp_i = pat[i];
      beat_q.push_back(b[k]);
      if (pat[i]) k++;
      @(posedge clk); #1;
    end
    resp_i = 1'b0;
    @(posedge clk); #1;
    exp_wr++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b1;
    address_i = 32'hFFFF_FFFF; line_i = '1; burst_i = '1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_o", {255'd0, read_o}, 256'd0);
    check("rst_write_o", {255'd0, write_o}, 256'd0);
    check("rst_resp_o", {255'd0, resp_o}, 256'd0);
    check("rst_line_o", line_o, 256'd0);
    check("rst_address_o", {224'd0, address_o}, 256'd0);
    check("rst_burst_o", {192'd0, burst_o}, 256'd0);
    rst = 1'b1; read_i = 1'b0; resp_i = 1'b0; burst_i = '0; line_i = '0; address_i = '0;
    @(posedge clk); #1;

    // basic read
    do_read(32'h0000_1234, 32'h0000_1220, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
            64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444, 1'b0);

    // write with gapped accepts 1,0,1,0,1,0,1
    do_write(32'h0000_2047, 32'h0000_2040, 64'hAAAA_AAAA_AAAA_AAAB, 64'hAAAA_AAAA_AAAA_AAA1,
             64'hAAAA_AAAA_AAAA_AAA2, 64'hAAAA_AAAA_AAAA_AAA3, 8'b0101_0101, 7);

    // simultaneous read and write requests: read wins
    do_read(32'h3FFF_FFFF, 32'h3FFF_FFE0, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
            64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1);
`ifdef L2_ADAPTOR_PERF_EN
    check("both_wr_count", {224'd0, wr_count}, 256'(exp_wr));
    check("both_rd_count", {224'd0, rd_count}, 256'(exp_rd));
`endif

    // resp_i held in IDLE without a request
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_resp_o", {255'd0, resp_o}, 256'd0);
      check("idle_read_o", {255'd0, read_o}, 256'd0);
    end
    resp_i = 1'b0; burst_i = '0;
    check("idle_line_o", line_o, last_line);
    check("idle_address_o", {224'd0, address_o}, {224'd0, last_addr});

    // reset after two read beats
    read_i = 1'b1; address_i = 32'h0000_4010;
    @(posedge clk); #1;
    read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      burst_i = 64'h5555_5555_5555_5550 + 64'(i); resp_i = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; resp_i = 1'b0; burst_i = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst_read_o", {255'd0, read_o}, 256'd0);
    check("midrst_line_o", line_o, 256'd0);
    check("midrst_resp_o", {255'd0, resp_o}, 256'd0);
    check("midrst_address_o", {224'd0, address_o}, 256'd0);
    last_line = '0; last_addr = '0; exp_rd = 0; exp_wr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_still_idle", {254'd0, read_o, write_o}, 256'd0);

    // traffic after reset: 3 reads, 2 writes
    do_read(32'h0000_5008, 32'h0000_5000, 64'h6666_0000_0000_0001, 64'h6666_0000_0000_0002,
            64'h6666_0000_0000_0003, 64'h6666_0000_0000_0004, 1'b0);
    do_write(32'h0000_6000, 32'h0000_6000, 64'h7777_0000_0000_0001, 64'h7777_0000_0000_0002,
             64'h7777_0000_0000_0003, 64'h7777_0000_0000_0004, 8'b0000_1111, 4);
    do_read(32'h0000_701F, 32'h0000_7000, 64'h8888_0000_0000_0001, 64'h8888_0000_0000_0002,
            64'h8888_0000_0000_0003, 64'h8888_0000_0000_0004, 1'b0);
    do_write(32'h0000_8021, 32'h0000_8020, 64'h9999_0000_0000_0001, 64'h9999_0000_0000_0002,
             64'h9999_0000_0000_0003, 64'h9999_0000_0000_0004, 8'b0001_1011, 5);
    do_read(32'h0000_9040, 32'h0000_9040, 64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0002,
            64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0004, 1'b0);
`ifdef L2_ADAPTOR_PERF_EN
    check("perf_rd_count", {224'd0, rd_count}, 256'd3);
    check("perf_wr_count", {224'd0, wr_count}, 256'd2);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("resp_q_drained", 256'(resp_q.size()), 256'd0);
    check("beat_q_drained", 256'(beat_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/l2_mem_adaptor.md
L2_MEM_ADAPTOR -- requirements
Module: l2_mem_adaptor

Interface
REQ-001 The module SHALL have these ports: clk, input, 1, clock; all state changes on the rising edge.
REQ-002 The module SHALL have these ports: rst, input, 1, synchronous active-low reset.
REQ-003 The module SHALL have these cache-side ports: line_i, input, 256, write line; line_o, output, 256, assembled read line; address_i, input, 32, line address; read_i, input, 1, line read request; write_i, input, 1, line write request; resp_o, output, 1, one-cycle completion pulse.
REQ-004 The module SHALL have these memory-side ports: burst_o, output, 64, write beat; burst_i, input, 64, read beat; address_o, output, 32, burst address; read_o, output, 1, burst read request; write_o, output, 1, burst write request; resp_i, input, 1, beat valid/accepted.
REQ-005 The module SHALL have these ports when L2_ADAPTOR_PERF_EN is defined: rd_count_o, output, 32, completed read lines; wr_count_o, output, 32, completed write lines.

Function
REQ-006 The state machine SHALL have exactly the states IDLE, RD_BURST, WR_BURST and DONE.
REQ-007 In IDLE with read_i=1, the module SHALL latch {address_i[31:5],5'b0} into address_o, clear the beat counter, and go to RD_BURST.
REQ-008 In IDLE with write_i=1 and read_i=0, the module SHALL latch the aligned address and line_i, clear the beat counter, and go to WR_BURST.
REQ-009 When read_i and write_i are both high in IDLE, read SHALL win and write_i SHALL be ignored.
REQ-010 The module SHALL assert read_o only in RD_BURST and write_o only in WR_BURST, with both driven from state registers and never combinationally from requests.
REQ-011 In RD_BURST, each cycle with resp_i=1 SHALL store burst_i into line_o[64*cnt +: 64] and increment the 2-bit counter cnt; cycles with resp_i=0 SHALL hold both.
REQ-012 In WR_BURST, the module SHALL drive burst_o with latched_line[64*cnt +: 64] every cycle, and each cycle with resp_i=1 SHALL advance cnt.
REQ-013 After the beat with cnt=3 and resp_i=1 is accepted, the module SHALL go to DONE, deassert read_o/write_o the next cycle, and reset cnt to 0 on wrap.
REQ-014 In DONE, the module SHALL hold resp_o=1 for exactly one cycle, ignore read_i/write_i, and go to IDLE next.
REQ-015 line_o SHALL remain stable from the DONE cycle until the next read beat is stored; a write SHALL NOT modify line_o.
REQ-016 Latency with resp_i high on every beat SHALL be: request sampled cycle 0, beats cycles 1-4, resp_o cycle 5, next request accepted cycle 6.
REQ-017 The module SHALL ignore resp_i in IDLE and DONE, with no state or data change.
REQ-018 address_o SHALL hold the latched value until the next request is accepted; burst_o SHALL be 0 outside WR_BURST.

Reset
REQ-019 When rst=0 at a clock edge, the module SHALL force state IDLE, cnt 0, line_o 0, address_o 0, the latched line 0, and read_o/write_o/resp_o/burst_o 0.
REQ-020 A reset mid-burst SHALL abandon the burst with no resp_o pulse and no partial line_o retained.

Configuration
REQ-021 With L2_ADAPTOR_PERF_EN defined, rd_count_o/wr_count_o SHALL each increment by 1 in the DONE cycle of a read/write, wrap at 2^32, and reset to 0.
REQ-022 Without L2_ADAPTOR_PERF_EN, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-023 The bench SHALL cover: read_i, address_i=0x0000_1234, beats 0x11..,0x22..,0x33..,0x44.. on consecutive resp_i -> address_o=0x0000_1220, line_o={0x44..,0x33..,0x22..,0x11..}, resp_o high at cycle 5 only.
REQ-024 The bench SHALL cover: write_i, line_i=256'hA..B with resp_i toggling 1,0,1,0,1,0,1 -> burst_o steps through 4 beats low-first, with each beat held through resp_i=0 gaps, and resp_o one cycle after the 4th accept.
REQ-025 The bench SHALL cover: read_i=write_i=1 in IDLE -> read_o=1, write_o=0, and wr_count_o unchanged.
REQ-026 The bench SHALL cover: rst=0 after 2 read beats -> next cycle IDLE, read_o=0, line_o=0, no resp_o; a new read then completes normally.
REQ-027 The bench SHALL cover: resp_i=1 held in IDLE with no request -> no state change and no resp_o.
REQ-028 The bench SHALL cover: with PERF_EN, 3 reads then 2 writes -> rd_count_o=3 and wr_count_o=2.
